// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state, access owner and the latched request.
package dmem_arb_pkg;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

  typedef enum logic {OWN_CPU, OWN_DMA} arb_owner_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// CPU, DMA and memory-side signals of the data-memory arbiter.
interface dmem_access_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              stall_cpu;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_valid;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ready;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output stall_cpu, cpu_rdata,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester/memory environment side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  stall_cpu, cpu_rdata,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_wait_timer.sv
// Counts the BUSY phase of one memory access: 0..WAIT_STATES after start, done on the last count.
module dmem_wait_timer #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CntW-1:0] wait_cnt_q;
  logic            active_q;
  logic            last;

  assign last = (wait_cnt_q == CntW'(WAIT_STATES));
  assign done = active_q && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q   <= 1'b0;
      wait_cnt_q <= '0;
    end else if (start) begin
      active_q   <= 1'b1;
      wait_cnt_q <= '0;
    end else if (active_q) begin
      if (last) begin
        active_q   <= 1'b0;
        wait_cnt_q <= '0;
      end else begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the single-port data memory between the MEM stage and a DMA port, one access at a time,
// stalling the CPU until its access completes and starving-protecting the DMA requester.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = REQ_ADDR_W,
  parameter int unsigned DATA_W      = REQ_DATA_W,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input logic                  clk,
  input logic                  rst,
  dmem_access_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  // The latched request struct is sized by the package; reject mismatched builds.
  if (ADDR_W != REQ_ADDR_W || DATA_W != REQ_DATA_W || STARVE_MAX < 1) begin : g_param_check
    $error("dmem_access_arbiter: unsupported parameter combination");
  end

  arb_state_t          state_q;
  arb_owner_t          owner_q;
  arb_req_t            req_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [StarveW-1:0]  starve_cnt_q;

  logic grant_cpu;
  logic grant_dma;
  logic dma_forced;
  logic timer_done;

  assign dma_forced = bus.dma_valid && (starve_cnt_q == StarveW'(STARVE_MAX));
  assign grant_cpu  = (state_q == IDLE) && bus.cpu_req && !dma_forced;
  assign grant_dma  = (state_q == IDLE) && bus.dma_valid && !grant_cpu;

  dmem_wait_timer #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .start(grant_cpu || grant_dma),
    .done (timer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      req_q        <= '0;
      rdata_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_dma) begin
            owner_q      <= OWN_DMA;
            req_q        <= '{we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};
            starve_cnt_q <= '0;
            state_q      <= BUSY;
          end else if (grant_cpu) begin
            owner_q <= OWN_CPU;
            req_q   <= '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
            if (bus.dma_valid && starve_cnt_q != StarveW'(STARVE_MAX)) begin
              starve_cnt_q <= starve_cnt_q + StarveW'(1);
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (timer_done) begin
            rdata_q <= bus.mem_rdata;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en     = (state_q == BUSY);
  // Write strobe only on the final BUSY cycle so a reset mid-access never commits the write.
  assign bus.mem_we     = (state_q == BUSY) && timer_done && req_q.we;
  assign bus.mem_addr   = req_q.addr;
  assign bus.mem_wdata  = req_q.wdata;

  assign bus.stall_cpu  = bus.cpu_req && !((state_q == RESP) && (owner_q == OWN_CPU));
  assign bus.cpu_rdata  = rdata_q;

  assign bus.dma_ready  = rst && grant_dma;
  assign bus.dma_rvalid = (state_q == RESP) && (owner_q == OWN_DMA);
  assign bus.dma_rdata  = rdata_q;

endmodule
